spilling_scan_uc: RTL and testbench

Parametrised successor to the Spilling game control unit. It sequences a full round: reset datapath, measure each of N sensors with a per-sensor handshake, wait a settle interval, load the servo/disc stage, then serialise N_BYTES per sensor over the TX. The sensor, byte and timer counters are internal rather than in the datapath. Adds timeouts with an error state, single-cycle start pulses, and a continuous (auto-repeat) mode.

---
 rtl/spilling_pkg.sv | 39 +++
 rtl/spilling_timer.sv | 38 +++
 rtl/spilling_scan_uc.sv | 171 +++++++++++++++++
 tb/tb_spilling_scan_uc.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spilling_pkg.sv
// Shared definitions for the Spilling round sequencer: state codes and
// elaboration-time width helpers used by the control unit and its timer.
package spilling_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'h0,
    S_RESET   = 4'h1,
    S_MEDIR   = 4'h2,
    S_ESP_MED = 4'h3,
    S_ESP_SEG = 4'h4,
    S_MOVE    = 4'h5,
    S_ENVIA   = 4'h6,
    S_ESP_TX  = 4'h7,
    S_PROX    = 4'h8,
    S_FINAL   = 4'h9,
    S_ERRO    = 4'hE
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'hF;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Index buses keep at least one bit even when only one item exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return max_u(1, clog2(n));
  endfunction

endpackage

// File: rtl/spilling_timer.sv
// Wait-state cycle counter with terminal-count flags for the settle,
// measurement-timeout and TX-timeout intervals.
module spilling_timer
  import spilling_pkg::*;
#(
  parameter int unsigned T_SEG = 50_000_000,
  parameter int unsigned T_MED = 1_500_000,
  parameter int unsigned T_TX  = 100_000
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic fim_seg,
  output logic fim_med,
  output logic fim_tx
);

  localparam int unsigned T_MAX = max_u(T_SEG, max_u(T_MED, T_TX));
  localparam int unsigned TW    = max_u(1, clog2(T_MAX));

  logic [TW-1:0] timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (limpa) begin
      timer <= '0;
    end else if (conta) begin
      timer <= timer + 1'b1;
    end
  end

  assign fim_seg = (timer == TW'(T_SEG - 1));
  assign fim_med = (timer == TW'(T_MED - 1));
  assign fim_tx  = (timer == TW'(T_TX - 1));

endmodule

// File: rtl/spilling_scan_uc.sv
// Spilling game control unit: sequences reset, per-sensor measurement,
// settle wait, disc load and per-sensor/per-byte serial transmission.
module spilling_scan_uc
  import spilling_pkg::*;
#(
  parameter int unsigned N_SENSORES = 3,
  parameter int unsigned N_BYTES    = 4,
  parameter int unsigned T_SEG      = 50_000_000,
  parameter int unsigned T_MED      = 1_500_000,
  parameter int unsigned T_TX       = 100_000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                jogar,
  input  logic                                continuo,
  input  logic                                pronto_medida,
  input  logic                                pronto_serial,
  output logic                                zera,
  output logic                                medir,
  output logic                                carrega_disc,
  output logic                                partida_tx,
  output logic [idx_width(N_SENSORES)-1:0]    sel_sensor,
  output logic [idx_width(N_BYTES)-1:0]       sel_byte,
  output logic                                pronto,
  output logic                                erro,
  output logic [3:0]                          db_estado
);

  localparam int unsigned SW = idx_width(N_SENSORES);
  localparam int unsigned BW = idx_width(N_BYTES);
  localparam logic [SW-1:0] ULT_SENSOR = SW'(N_SENSORES - 1);
  localparam logic [BW-1:0] ULT_BYTE   = BW'(N_BYTES - 1);

  estado_t       estado_q, estado_d;
  logic [SW-1:0] sensor_q, sensor_d;
  logic [BW-1:0] byte_q, byte_d;
  logic          timer_limpa, timer_conta;
  logic          fim_seg, fim_med, fim_tx;

  spilling_timer #(
    .T_SEG (T_SEG),
    .T_MED (T_MED),
    .T_TX  (T_TX)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .limpa   (timer_limpa),
    .conta   (timer_conta),
    .fim_seg (fim_seg),
    .fim_med (fim_med),
    .fim_tx  (fim_tx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= S_IDLE;
      sensor_q <= '0;
      byte_q   <= '0;
    end else begin
      estado_q <= estado_d;
      sensor_q <= sensor_d;
      byte_q   <= byte_d;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    sensor_d     = sensor_q;
    byte_d       = byte_q;
    zera         = 1'b0;
    medir        = 1'b0;
    carrega_disc = 1'b0;
    partida_tx   = 1'b0;
    pronto       = 1'b0;
    erro         = 1'b0;
    timer_conta  = 1'b0;

    case (estado_q)
      S_IDLE: begin
        if (jogar) estado_d = S_RESET;
      end
      S_RESET: begin
        zera     = 1'b1;
        sensor_d = '0;
        byte_d   = '0;
        estado_d = S_MEDIR;
      end
      S_MEDIR: begin
        medir    = 1'b1;
        estado_d = S_ESP_MED;
      end
      S_ESP_MED: begin
        timer_conta = 1'b1;
        // A completion arriving on the last allowed cycle beats the timeout.
        if (pronto_medida) begin
          if (sensor_q == ULT_SENSOR) begin
            sensor_d = '0;
            estado_d = S_ESP_SEG;
          end else begin
            sensor_d = sensor_q + 1'b1;
            estado_d = S_MEDIR;
          end
        end else if (fim_med) begin
          estado_d = S_ERRO;
        end
      end
      S_ESP_SEG: begin
        timer_conta = 1'b1;
        if (fim_seg) estado_d = S_MOVE;
      end
      S_MOVE: begin
        carrega_disc = 1'b1;
        estado_d     = S_ENVIA;
      end
      S_ENVIA: begin
        partida_tx = 1'b1;
        estado_d   = S_ESP_TX;
      end
      S_ESP_TX: begin
        timer_conta = 1'b1;
        if (pronto_serial) begin
          estado_d = S_PROX;
        end else if (fim_tx) begin
          estado_d = S_ERRO;
        end
      end
      S_PROX: begin
        if (byte_q != ULT_BYTE) begin
          byte_d   = byte_q + 1'b1;
          estado_d = S_ENVIA;
        end else begin
          byte_d = '0;
          if (sensor_q != ULT_SENSOR) begin
            sensor_d = sensor_q + 1'b1;
            estado_d = S_ENVIA;
          end else begin
            estado_d = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        pronto   = 1'b1;
        sensor_d = '0;
        byte_d   = '0;
        estado_d = continuo ? S_RESET : S_IDLE;
      end
      S_ERRO: begin
        erro = 1'b1;
        if (jogar) estado_d = S_RESET;
      end
      default: begin
        estado_d = S_IDLE;
      end
    endcase

    // Any state change restarts the interval count from zero.
    timer_limpa = (estado_d != estado_q);
  end

  always_comb begin
    case (estado_q)
      S_IDLE, S_RESET, S_MEDIR, S_ESP_MED, S_ESP_SEG, S_MOVE,
      S_ENVIA, S_ESP_TX, S_PROX, S_FINAL, S_ERRO: db_estado = estado_q;
      default:                                     db_estado = DB_INVALIDO;
    endcase
  end

  assign sel_sensor = sensor_q;
  assign sel_byte   = byte_q;

endmodule

// File: tb/tb_spilling_scan_uc.sv
// Bench for spilling_scan_uc: randomised response latencies checked against
// round-level expectations (pulse order, settle length, total round length).
module tb_spilling_scan_uc;

  localparam int NS   = 2;
  localparam int NB   = 2;
  localparam int TSEG = 4;
  localparam int TMED = 8;
  localparam int TTX  = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b0, jogar = 1'b0, continuo = 1'b0;
  logic       pronto_medida = 1'b0, pronto_serial = 1'b0;
  logic       zera, medir, carrega_disc, partida_tx, pronto, erro;
  logic [0:0] sel_sensor, sel_byte;
  logic [3:0] db_estado;

  logic       jogar1 = 1'b0, pm1 = 1'b0, ps1 = 1'b0;
  logic       zera1, medir1, disc1, tx1, pronto1, erro1;
  logic [0:0] ss1, sb1;
  logic [3:0] db1;

  spilling_scan_uc #(
    .N_SENSORES (NS), .N_BYTES (NB), .T_SEG (TSEG), .T_MED (TMED), .T_TX (TTX)
  ) dut (
    .clock (clock), .reset (reset), .jogar (jogar), .continuo (continuo),
    .pronto_medida (pronto_medida), .pronto_serial (pronto_serial),
    .zera (zera), .medir (medir), .carrega_disc (carrega_disc),
    .partida_tx (partida_tx), .sel_sensor (sel_sensor), .sel_byte (sel_byte),
    .pronto (pronto), .erro (erro), .db_estado (db_estado)
  );

  spilling_scan_uc #(
    .N_SENSORES (1), .N_BYTES (1), .T_SEG (TSEG), .T_MED (TMED), .T_TX (TTX)
  ) dut1 (
    .clock (clock), .reset (reset), .jogar (jogar1), .continuo (1'b0),
    .pronto_medida (pm1), .pronto_serial (ps1),
    .zera (zera1), .medir (medir1), .carrega_disc (disc1),
    .partida_tx (tx1), .sel_sensor (ss1), .sel_byte (sb1),
    .pronto (pronto1), .erro (erro1), .db_estado (db1)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  int     dm_tab[NS];
  int     dt_tab[NS*NB];
  longint med_enc, tx_enc;
  int     reset_t[$], pronto_t[$];
  int     last_medir_t, last_tx_t, seg_cycles, erro_t;

  task automatic tick();
    @(posedge clock);
    #1;
    t++;
  endtask

  // Model: total cycles RESET..FINAL for the current latency tables.
  function automatic int round_len();
    int n;
    n = 1 + TSEG + 1 + 1;
    for (int s = 0; s < NS; s++) n += 1 + dm_tab[s];
    for (int k = 0; k < NS*NB; k++) n += 2 + dt_tab[k];
    return n;
  endfunction

  function automatic longint exp_med(input int rounds);
    longint e;
    e = 0;
    for (int r = 0; r < rounds; r++)
      for (int s = 0; s < NS; s++) e = e * 8 + s + 1;
    return e;
  endfunction

  function automatic longint exp_tx(input int rounds);
    longint e;
    e = 0;
    for (int r = 0; r < rounds; r++)
      for (int s = 0; s < NS; s++)
        for (int b = 0; b < NB; b++) e = e * 8 + s * NB + b + 1;
    return e;
  endfunction

  task automatic randomize_tables(input int lo, input int hi);
    for (int s = 0; s < NS; s++) dm_tab[s] = $urandom_range(hi, lo);
    for (int k = 0; k < NS*NB; k++) dt_tab[k] = $urandom_range(hi, lo);
  endtask

  task automatic start_round();
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
  endtask

  // Acts as sensor and serial responder; mode 0 stops after n_pronto pronto
  // pulses, mode 1 on erro, mode 2 in ESP_TX for sensor 1 byte 1.
  task automatic run(input int mode, input int n_pronto, input bit poke_envia,
                     output bit timed_out);
    int m_at, s_at;
    m_at = -1; s_at = -1;
    med_enc = 0; tx_enc = 0; seg_cycles = 0; erro_t = -1;
    reset_t.delete(); pronto_t.delete();
    timed_out = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (zera) reset_t.push_back(t);
      if (medir) begin
        med_enc = med_enc * 8 + int'(sel_sensor) + 1;
        last_medir_t = t;
        m_at = t + dm_tab[sel_sensor];
      end
      if (partida_tx) begin
        tx_enc = tx_enc * 8 + int'(sel_sensor) * NB + int'(sel_byte) + 1;
        last_tx_t = t;
        s_at = t + dt_tab[int'(sel_sensor) * NB + int'(sel_byte)];
      end
      if (db_estado == 4'h4) seg_cycles++;
      if (pronto) pronto_t.push_back(t);
      if (erro && erro_t < 0) erro_t = t;
      pronto_medida = (t == m_at);
      pronto_serial = (t == s_at);
      jogar = poke_envia && (db_estado == 4'h6);
      if ((mode == 0 && pronto_t.size() == n_pronto) ||
          (mode == 1 && erro_t >= 0) ||
          (mode == 2 && db_estado == 4'h7 && sel_sensor == 1'b1 && sel_byte == 1'b1)) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    pronto_medida = 1'b0;
    pronto_serial = 1'b0;
    jogar = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; jogar = 1'b1; continuo = 1'b1; pronto_medida = 1'b1; pronto_serial = 1'b1;
    tick(); tick();
    checks++;
    if ({zera, medir, carrega_disc, partida_tx, pronto, erro, sel_sensor, sel_byte, db_estado} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {zera, medir, carrega_disc, partida_tx, pronto, erro, sel_sensor, sel_byte, db_estado});
    end
    reset = 1'b0; jogar = 1'b0; continuo = 1'b0; pronto_medida = 1'b0; pronto_serial = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle: db_estado %h required 0", db_estado);
    end
  endtask

  task automatic check_round(input string tag, input bit to, input int rounds);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout: round did not complete", tag); end
    checks++;
    if (med_enc !== exp_med(rounds)) begin
      errors++; $display("FAIL %s_medir_order: got %0d required %0d", tag, med_enc, exp_med(rounds));
    end
    checks++;
    if (tx_enc !== exp_tx(rounds)) begin
      errors++; $display("FAIL %s_tx_order: got %0d required %0d", tag, tx_enc, exp_tx(rounds));
    end
    checks++;
    if (seg_cycles !== TSEG * rounds) begin
      errors++; $display("FAIL %s_settle: got %0d required %0d", tag, seg_cycles, TSEG * rounds);
    end
    checks++;
    if (erro_t !== -1) begin
      errors++; $display("FAIL %s_no_error: erro seen at %0d required none", tag, erro_t);
    end
    if (!to && reset_t.size() >= rounds && pronto_t.size() >= rounds) begin
      for (int r = 0; r < rounds; r++) begin
        checks++;
        if (pronto_t[r] - reset_t[r] + 1 !== round_len()) begin
          errors++;
          $display("FAIL %s_length: got %0d required %0d", tag, pronto_t[r] - reset_t[r] + 1, round_len());
        end
      end
    end else begin
      checks++; errors++;
      $display("FAIL %s_events: reset %0d pronto %0d required %0d each", tag, reset_t.size(), pronto_t.size(), rounds);
    end
  endtask

  task automatic test_normal_round();
    bit to;
    for (int s = 0; s < NS; s++) dm_tab[s] = 2;
    for (int k = 0; k < NS*NB; k++) dt_tab[k] = 3;
    start_round();
    run(0, 1, 1'b0, to);
    check_round("normal", to, 1);
    tick();
    checks++;
    if (db_estado !== 4'h0 || pronto !== 1'b0) begin
      errors++; $display("FAIL normal_back_idle: db %h pronto %b required 0 0", db_estado, pronto);
    end
  endtask

  task automatic test_random_rounds();
    bit to;
    for (int i = 0; i < 6; i++) begin
      randomize_tables(1, TMED);
      start_round();
      run(0, 1, 1'b0, to);
      check_round("random", to, 1);
      tick();
    end
  endtask

  task automatic test_med_timeout();
    bit to;
    dm_tab[0] = 2; dm_tab[1] = 1000;
    for (int k = 0; k < NS*NB; k++) dt_tab[k] = 3;
    start_round();
    run(1, 0, 1'b0, to);
    checks++;
    if (to || erro_t - last_medir_t !== TMED + 1) begin
      errors++; $display("FAIL med_timeout_latency: got %0d required %0d", erro_t - last_medir_t, TMED + 1);
    end
    checks++;
    if (erro !== 1'b1 || db_estado !== 4'hE) begin
      errors++; $display("FAIL med_timeout_state: erro %b db %h required 1 e", erro, db_estado);
    end
    pronto_medida = 1'b1; pronto_serial = 1'b1; continuo = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pronto_medida = 1'b0; pronto_serial = 1'b0; continuo = 1'b0;
    checks++;
    if (erro !== 1'b1 || db_estado !== 4'hE) begin
      errors++; $display("FAIL erro_hold: erro %b db %h required 1 e", erro, db_estado);
    end
    dm_tab[1] = 2;
    start_round();
    checks++;
    if (zera !== 1'b1 || db_estado !== 4'h1) begin
      errors++; $display("FAIL erro_restart: zera %b db %h required 1 1", zera, db_estado);
    end
    run(0, 1, 1'b0, to);
    check_round("restart", to, 1);
    tick();
  endtask

  task automatic test_tx_tie();
    bit to;
    for (int s = 0; s < NS; s++) dm_tab[s] = 2;
    for (int k = 0; k < NS*NB; k++) dt_tab[k] = 3;
    dt_tab[0] = TTX;
    start_round();
    run(0, 1, 1'b0, to);
    check_round("tx_tie", to, 1);
    tick();
    dt_tab[0] = 3; dt_tab[1] = TTX + 1;
    start_round();
    run(1, 0, 1'b0, to);
    checks++;
    if (to || erro_t - last_tx_t !== TTX + 1) begin
      errors++; $display("FAIL tx_timeout_latency: got %0d required %0d", erro_t - last_tx_t, TTX + 1);
    end
    checks++;
    if (tx_enc !== 64'd10 || db_estado !== 4'hE) begin
      errors++; $display("FAIL tx_timeout_state: tx %0d db %h required 10 e", tx_enc, db_estado);
    end
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic test_continuous();
    bit to;
    randomize_tables(1, 5);
    continuo = 1'b1;
    start_round();
    run(0, 2, 1'b0, to);
    check_round("continuo", to, 2);
    checks++;
    if (!to && reset_t.size() >= 2 && reset_t[1] !== pronto_t[0] + 1) begin
      errors++; $display("FAIL continuo_restart: reset at %0d required %0d", reset_t[1], pronto_t[0] + 1);
    end
    continuo = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'h0) begin
      errors++; $display("FAIL continuo_stop: db %h required 0", db_estado);
    end
  endtask

  task automatic test_async_reset();
    bit to;
    for (int s = 0; s < NS; s++) dm_tab[s] = 2;
    for (int k = 0; k < NS*NB; k++) dt_tab[k] = 3;
    start_round();
    run(2, 0, 1'b1, to);
    checks++;
    if (to || med_enc !== exp_med(1) || tx_enc !== exp_tx(1)) begin
      errors++; $display("FAIL jogar_in_envia: med %0d tx %0d required %0d %0d",
                         med_enc, tx_enc, exp_med(1), exp_tx(1));
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({zera, medir, carrega_disc, partida_tx, pronto, erro, sel_sensor, sel_byte, db_estado} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b required all zero",
               {zera, medir, carrega_disc, partida_tx, pronto, erro, sel_sensor, sel_byte, db_estado});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_degenerate();
    int n_med, n_tx, n_pr, n_sel, r_t, p_t, m_at, s_at;
    n_med = 0; n_tx = 0; n_pr = 0; n_sel = 0; r_t = -1; p_t = -1; m_at = -1; s_at = -1;
    jogar1 = 1'b1; tick(); jogar1 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (zera1 && r_t < 0) r_t = t;
      if (medir1) begin n_med++; m_at = t + 2; end
      if (tx1) begin n_tx++; s_at = t + 2; end
      if (ss1 !== 1'b0 || sb1 !== 1'b0) n_sel++;
      if (pronto1) begin n_pr++; p_t = t; end
      pm1 = (t == m_at);
      ps1 = (t == s_at);
      if (db1 == 4'h0 && p_t >= 0) break;
      tick();
    end
    pm1 = 1'b0; ps1 = 1'b0;
    checks++;
    if (n_med !== 1 || n_tx !== 1 || n_pr !== 1) begin
      errors++; $display("FAIL degenerate_pulses: medir %0d tx %0d pronto %0d required 1 1 1", n_med, n_tx, n_pr);
    end
    checks++;
    if (n_sel !== 0) begin
      errors++; $display("FAIL degenerate_indices: nonzero %0d cycles required 0", n_sel);
    end
    checks++;
    if (p_t - r_t + 1 !== 1 + 3 + TSEG + 1 + 4 + 1) begin
      errors++; $display("FAIL degenerate_length: got %0d required %0d", p_t - r_t + 1, 1 + 3 + TSEG + 1 + 4 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_normal_round();
    test_random_rounds();
    test_med_timeout();
    test_tx_tie();
    test_continuous();
    test_async_reset();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
